hs_arbiter: RTL and testbench

Clocked four-phase handshake arbiter. It shares one bundled-data request/acknowledge channel, such as the input of a join stage or another C-element pipeline stage, between `NUM_REQ` four-phase requesters. It synchronises the asynchronous request and acknowledge wires, picks one requester by round-robin, registers that requester's data and presents it downstream with a delayed request. It then sequences the full four-phase return-to-zero cycle before granting again, and flags protocol violations.

---
 rtl/hs_arbiter_if.sv | 25 ++
 rtl/hs_arbiter.sv | 166 ++++++++++++++++
 tb/tb_hs_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_arbiter_if.sv
// Bundled-data four-phase channel between the requesters/downstream stage and hs_arbiter.
// Signal directions are named from the arbiter's point of view.
interface hs_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*DW-1:0] data_i;
    logic [NUM_REQ-1:0]    ack_o;
    logic                  req_out_o;
    logic [DW-1:0]         data_out_o;
    logic                  ack_out_i;
    logic [NUM_REQ-1:0]    grant_o;
    logic                  proto_err_o;

    modport slave (
        input  req_i, data_i, ack_out_i,
        output ack_o, req_out_o, data_out_o, grant_o, proto_err_o
    );

    modport master (
        output req_i, data_i, ack_out_i,
        input  ack_o, req_out_o, data_out_o, grant_o, proto_err_o
    );
endinterface

// File: rtl/hs_arbiter.sv
// Round-robin arbiter sharing one four-phase bundled-data channel between NUM_REQ requesters.
//
// state   | meaning
// IDLE    | no owner; pick round-robin winner, register its data and grant
// LOAD    | data settled for one cycle; raise downstream request
// SEND    | wait for downstream ack, then ack the owner
// ACKED   | wait for owner to drop its request, then drop downstream request
// RELEASE | wait for downstream ack to fall, then release owner and advance pointer
module hs_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    hs_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Pointer resets to the last requester so the search starts at requester 0.
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ACKED,
        S_RELEASE
    } state_e;

    logic [NUM_REQ-1:0] sreq;
    logic               sack;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sreq = bus.req_i;
            assign sack = bus.ack_out_i;
        end else begin : g_sync
            logic [NUM_REQ-1:0]     req_sync_q [SYNC_STAGES];
            logic [SYNC_STAGES-1:0] ack_sync_q;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        req_sync_q[s] <= '0;
                    end
                    ack_sync_q <= '0;
                end else begin
                    req_sync_q[0] <= bus.req_i;
                    ack_sync_q[0] <= bus.ack_out_i;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        req_sync_q[s] <= req_sync_q[s-1];
                        ack_sync_q[s] <= ack_sync_q[s-1];
                    end
                end
            end

            assign sreq = req_sync_q[SYNC_STAGES-1];
            assign sack = ack_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_e             state_q;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      last_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               req_out_q;
    logic               proto_err_q;
    logic [DW-1:0]      data_out_q;

    logic               win_valid;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               owner_req;
    logic               err_now;

    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_q) + i) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!win_valid && sreq[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    assign owner_req = sreq[owner_q];

    always_comb begin
        err_now = 1'b0;
        case (state_q)
            S_IDLE:  err_now = sack;
            S_LOAD:  err_now = sack | ~owner_req;
            S_SEND:  err_now = ~owner_req;
            S_ACKED: err_now = ~sack;
            default: err_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            ack_q       <= '0;
            grant_q     <= '0;
            req_out_q   <= 1'b0;
            proto_err_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        owner_q    <= win_idx;
                        grant_q    <= win_onehot;
                        data_out_q <= bus.data_i[int'(win_idx)*DW +: DW];
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    req_out_q <= 1'b1;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    if (sack) begin
                        ack_q[owner_q] <= 1'b1;
                        state_q        <= S_ACKED;
                    end
                end
                S_ACKED: begin
                    if (!owner_req) begin
                        req_out_q <= 1'b0;
                        state_q   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!sack) begin
                        ack_q   <= '0;
                        grant_q <= '0;
                        last_q  <= owner_q;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Violations are only logged; the handshake carries on regardless.
            if (err_now) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.req_out_o   = req_out_q;
    assign bus.data_out_o  = data_out_q;
    assign bus.grant_o     = grant_q;
    assign bus.proto_err_o = proto_err_q;
endmodule

// File: tb/tb_hs_arbiter.sv
// Bench for hs_arbiter: event-timed transaction model plus directed reset, violation and bypass cases.
module tb_hs_arbiter;
    localparam int N   = 2;
    localparam int DW  = 8;
    localparam int S   = 2;
    localparam int INF = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hs_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus  ();
    hs_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus0 ();

    hs_arbiter #(.NUM_REQ(N), .DW(DW), .SYNC_STAGES(S)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    hs_arbiter #(.NUM_REQ(N), .DW(DW), .SYNC_STAGES(0)) dut_byp (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus0)
    );

    typedef enum {R_IDLE, R_REQ, R_DROP} rq_e;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    rq_e           rq_st    [N];
    int            rise_e   [N];
    logic [DW-1:0] dat      [N];
    int            raise_pct[N];
    int            drop_pct [N];

    bit ds_en   = 1'b1;
    bit ds_rand = 1'b0;
    int ds_dly  = 3;
    int ds_cnt  = 0;

    bit            chk_en = 1'b0;
    int            m_owner, m_last, m_ready, m_t, m_f, m_g, m_h;
    logic [DW-1:0] m_data;

    int           grant_log[$];
    logic [N-1:0] grant_prev = '0;
    logic [N-1:0] ack_seen   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic raise(input int k, input logic [DW-1:0] d);
        bus.req_i[k]             = 1'b1;
        bus.data_i[k*DW +: DW]   = d;
        dat[k]                   = d;
        rise_e[k]                = cyc + 1;
        rq_st[k]                 = R_REQ;
    endtask

    // Transaction model built from the edge-latency rules: grant at T, req_out from T+1 to G+S,
    // owner ack from F+S to H+S, release at H+S; round-robin from last+1 among settled requests.
    task automatic model_check();
        logic [N-1:0] eg;
        logic [N-1:0] eack;
        logic         erq;
        if (m_owner >= 0 && m_h != INF && cyc == m_h + S) begin
            m_last  = m_owner;
            m_owner = -1;
            m_ready = cyc + 1;
        end
        if (m_owner < 0 && cyc >= m_ready) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_last + i) % N;
                if (m_owner < 0 && rq_st[k] == R_REQ && rise_e[k] <= cyc - S) begin
                    m_owner = k;
                    m_t     = cyc;
                    m_f     = INF;
                    m_g     = INF;
                    m_h     = INF;
                    m_data  = dat[k];
                end
            end
        end
        eg   = '0;
        eack = '0;
        erq  = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            erq = (cyc >= m_t + 1) && (cyc < m_g + S);
            if (m_f != INF && cyc >= m_f + S) eack[m_owner] = 1'b1;
        end
        chk("grant",     bus.grant_o,     eg);
        chk("req_out",   bus.req_out_o,   erq);
        chk("ack",       bus.ack_o,       eack);
        chk("data_out",  bus.data_out_o,  m_data);
        chk("proto_err", bus.proto_err_o, 0);
    endtask

    task automatic stim();
        if (ds_en && bus.req_out_o != bus.ack_out_i) begin
            ds_cnt++;
            if (ds_cnt >= ds_dly) begin
                bus.ack_out_i = bus.req_out_o;
                ds_cnt = 0;
                if (m_owner >= 0) begin
                    if (bus.ack_out_i) m_f = cyc + 1;
                    else               m_h = cyc + 1;
                end
                if (ds_rand) ds_dly = $urandom_range(1, 4);
            end
        end else begin
            ds_cnt = 0;
        end
        for (int k = 0; k < N; k++) begin
            case (rq_st[k])
                R_REQ: if (bus.ack_o[k] && $urandom_range(0, 99) < drop_pct[k]) begin
                    bus.req_i[k] = 1'b0;
                    rq_st[k]     = R_DROP;
                    if (m_owner == k) m_g = cyc + 1;
                end
                R_DROP: if (!bus.ack_o[k]) rq_st[k] = R_IDLE;
                default: ;
            endcase
            if (rq_st[k] == R_IDLE && $urandom_range(0, 99) < raise_pct[k]) raise(k, DW'($urandom));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.grant_o != '0 && grant_prev == '0) grant_log.push_back(bus.grant_o[1] ? 1 : 0);
        grant_prev = bus.grant_o;
        ack_seen   = ack_seen | bus.ack_o;
        if (chk_en) model_check();
        stim();
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.req_i      = '0;
        bus.ack_out_i  = 1'b0;
        bus0.req_i     = '0;
        bus0.ack_out_i = 1'b0;
        bus0.data_i    = '0;
        for (int k = 0; k < N; k++) begin
            rq_st[k]     = R_IDLE;
            raise_pct[k] = 0;
            drop_pct[k]  = 100;
        end
        ds_cnt = 0;
        tick();
        chk("rst_grant",     bus.grant_o,     0);
        chk("rst_ack",       bus.ack_o,       0);
        chk("rst_req_out",   bus.req_out_o,   0);
        chk("rst_data_out",  bus.data_out_o,  0);
        chk("rst_proto_err", bus.proto_err_o, 0);
        rst_n   = 1'b1;
        m_owner = -1;
        m_last  = N - 1;
        m_ready = cyc + 1;
        m_data  = '0;
        grant_log.delete();
        ack_seen = '0;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.grant_o != '0;
            1:       return bus.grant_o == '0;
            2:       return bus.req_out_o;
            3:       return bus.ack_o[1];
            4:       return grant_log.size() >= 4;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input string tag, input int sel, input int budget);
        int n;
        n = 0;
        while (!cond(sel) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, cond(sel), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_i = '0;
        @(negedge clk);
        do_reset();

        // Bypass instance: synchronous inputs, no synchroniser latency.
        bus0.data_i[0 +: DW] = 8'h77;
        bus0.req_i = 2'b01;
        tick();
        chk("byp_grant",      bus0.grant_o,    2'b01);
        chk("byp_data",       bus0.data_out_o, 8'h77);
        chk("byp_req_out_e1", bus0.req_out_o,  0);
        tick();
        chk("byp_req_out_e2", bus0.req_out_o,  1);
        bus0.ack_out_i = 1'b1;
        tick();
        chk("byp_ack_rise",   bus0.ack_o,      2'b01);
        bus0.req_i = 2'b00;
        tick();
        chk("byp_req_out_fall", bus0.req_out_o, 0);
        bus0.ack_out_i = 1'b0;
        tick();
        chk("byp_ack_fall",   bus0.ack_o,      2'b00);
        chk("byp_release",    bus0.grant_o,    2'b00);
        chk("byp_proto_err",  bus0.proto_err_o, 0);

        // Single transaction.
        do_reset();
        chk_en = 1'b1;
        repeat (3) tick();
        raise(0, 8'hA5);
        wait_cond("single_grant", 0, 20);
        chk("single_grant_latency", cyc - rise_e[0], S);
        chk("single_data", bus.data_out_o, 8'hA5);
        wait_cond("single_release", 1, 60);
        chk("single_ack_seen", ack_seen, 2'b01);

        // Simultaneous requests, both re-requesting immediately.
        do_reset();
        chk_en = 1'b1;
        raise_pct[0] = 100;
        raise_pct[1] = 100;
        raise(0, 8'h11);
        raise(1, 8'h22);
        wait_cond("simul_four_grants", 4, 400);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("simul_order", grant_log[i], i % 2);

        // Fairness: requester 0 keeps re-requesting, requester 1 arrives once.
        do_reset();
        chk_en = 1'b1;
        raise_pct[0] = 100;
        raise(0, 8'h31);
        wait_cond("fair_first_grant", 0, 20);
        raise(1, 8'h42);
        repeat (80) tick();
        chk("fair_log_len", grant_log.size() >= 2, 1);
        if (grant_log.size() >= 2) chk("fair_second_is_1", grant_log[1], 1);

        // Reset while in ACKED, after requester 0 has just been served.
        do_reset();
        chk_en = 1'b1;
        raise(0, 8'h5A);
        wait_cond("mrst_first_release", 0, 20);
        wait_cond("mrst_first_done", 1, 60);
        drop_pct[1] = 0;
        raise(1, 8'hC3);
        wait_cond("mrst_acked", 3, 60);
        chk("mrst_pre_data", bus.data_out_o, 8'hC3);
        do_reset();
        chk_en = 1'b1;
        raise(0, 8'h01);
        raise(1, 8'h02);
        wait_cond("mrst_regrant", 0, 20);
        chk("mrst_rr_restart", bus.grant_o, 2'b01);
        wait_cond("mrst_regrant_done", 1, 60);

        // Request withdrawn during SEND.
        do_reset();
        drop_pct[0] = 0;
        raise(0, 8'h3C);
        wait_cond("wd_req_out", 2, 20);
        bus.req_i[0] = 1'b0;
        rq_st[0] = R_DROP;
        repeat (S + 1) tick();
        chk("wd_proto_err", bus.proto_err_o, 1);
        wait_cond("wd_completes", 1, 60);
        chk("wd_ack_seen", ack_seen, 2'b01);
        chk("wd_err_sticky", bus.proto_err_o, 1);

        // Spurious downstream acknowledge while idle.
        do_reset();
        ds_en = 1'b0;
        bus.ack_out_i = 1'b1;
        tick();
        bus.ack_out_i = 1'b0;
        repeat (S + 1) tick();
        chk("spur_proto_err", bus.proto_err_o, 1);
        chk("spur_no_grant",  bus.grant_o,     0);
        ds_en = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        chk_en  = 1'b1;
        ds_rand = 1'b1;
        for (int k = 0; k < N; k++) begin
            raise_pct[k] = $urandom_range(5, 40);
            drop_pct[k]  = 50;
        end
        repeat (3000) tick();
        chk("rand_grants_seen", grant_log.size() >= 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
